// File: rtl/scan_decoder.sv
// rtl/scan_decoder.sv - registered N-to-2^N active-low decoder with direct and auto-scan modes
// Optional anti-ghosting blanking is enabled by defining SCAN_BLANK_EN.
module scan_decoder #(
    parameter int SEL_W     = 2,
    parameter int DIV       = 50000,
    parameter int BLANK_CYC = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_dis,
    input  logic                i_mode,
    input  logic [SEL_W-1:0]    i_sel,
    output logic [2**SEL_W-1:0] o_y_n,
    output logic [SEL_W-1:0]    o_idx,
    output logic                o_tick
);
    localparam int N     = 2**SEL_W;
    localparam int CNT_W = $clog2(DIV);

    if (SEL_W < 1 || SEL_W > 4 || DIV < 2 || BLANK_CYC < 0 || BLANK_CYC >= DIV) begin : g_bad_param
        $error("scan_decoder: illegal parameter combination");
    end

    logic [CNT_W-1:0] r_cnt;
    logic [SEL_W-1:0] r_idx;
    logic [N-1:0]     r_y_n;
    logic             r_tick;
    logic             w_wrap;
    logic [SEL_W-1:0] w_idx_next;
    logic             w_blank;
    logic [N-1:0]     w_y_next;

    assign w_wrap = (r_cnt == CNT_W'(DIV - 1));

    always_comb begin
        w_idx_next = r_idx;
        if (i_dis)
            w_idx_next = r_idx;
        else if (!i_mode)
            w_idx_next = i_sel;
        else if (w_wrap)
            w_idx_next = r_idx + 1'b1;
    end

`ifdef SCAN_BLANK_EN
    localparam int BLANK_LOAD = (BLANK_CYC == 0) ? 0 : BLANK_CYC - 1;

    logic [CNT_W-1:0] r_blank;
    logic             w_chg;

    // r_blank holds the number of forced-off cycles still owed after the current one
    assign w_chg   = (w_idx_next != r_idx) && (BLANK_CYC != 0);
    assign w_blank = w_chg || (r_blank != '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_blank <= '0;
        else if (w_chg)
            r_blank <= CNT_W'(BLANK_LOAD);
        else if (r_blank != '0)
            r_blank <= r_blank - 1'b1;
    end
`else
    assign w_blank = 1'b0;
`endif

    assign w_y_next = (i_dis || w_blank) ? '1 : ~(N'(1) << w_idx_next);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
            r_idx  <= '0;
            r_y_n  <= '1;
        end else begin
            r_cnt  <= w_wrap ? '0 : r_cnt + 1'b1;
            r_tick <= w_wrap;
            r_idx  <= w_idx_next;
            r_y_n  <= w_y_next;
        end
    end

    assign o_y_n  = r_y_n;
    assign o_idx  = r_idx;
    assign o_tick = r_tick;

endmodule
